// File: rtl/monitor_event_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module   : monitor_pkg
// Purpose  : Shared types and helpers for the monitor event scheduler slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package monitor_pkg;

  localparam int DROP_W     = 16;
  localparam int EVT_CH_W   = 4;
  localparam int EVT_DATA_W = 8;
  localparam int EVT_TS_W   = 16;

  // Index width for a channel count; never collapses to zero bits.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Event record as seen by a trace sink built for the default widths.
  typedef struct packed {
    logic [EVT_CH_W-1:0]   ch;
    logic [EVT_DATA_W-1:0] data;
    logic [EVT_TS_W-1:0]   ts;
  } mon_evt_t;

endpackage

`default_nettype wire

// File: rtl/monitor_event_scheduler_if.sv
//------------------------------------------------------------------------------
// Module   : monitor_event_scheduler_if
// Purpose  : Probe-tap inputs plus the valid/ready event log port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface monitor_event_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
);
  localparam int CH_W = monitor_pkg::ch_w(NUM_CH);

  logic                     mon_en;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     log_valid;
  logic                     log_ready;
  logic [CH_W-1:0]          log_ch;
  logic [DATA_W-1:0]        log_data;
  logic [TS_W-1:0]          log_ts;

  // The scheduler is the log master; the trace sink is the slave.
  modport master (
    input  mon_en, ch_en, ch_data, log_ready,
    output log_valid, log_ch, log_data, log_ts
  );

  modport slave (
    output mon_en, ch_en, ch_data, log_ready,
    input  log_valid, log_ch, log_data, log_ts
  );

endinterface

`default_nettype wire

// File: rtl/monitor_event_scheduler_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mon_rr_arbiter
// Purpose  : Round-robin arbiter; owns the search pointer, moves it past a grant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mon_rr_arbiter
  import monitor_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IDX_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin : search
    int  idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (int'(gnt_idx_o) == NUM_CH - 1) ptr_d = '0;
      else                               ptr_d = gnt_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/monitor_event_scheduler.sv
//------------------------------------------------------------------------------
// Module   : monitor_event_scheduler
// Purpose  : Timestamps value changes on enabled channels onto one log port.
//            Define MON_DROP_CNT_EN to add the saturating drop_cnt output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module monitor_event_scheduler
  import monitor_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  monitor_event_scheduler_if.master  log_if
`ifdef MON_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]          drop_cnt
`endif
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [TS_W-1:0]   tstamp_q;
  logic [NUM_CH-1:0] act, act_q, trig, req, gnt, pend_q, pend_d;
  logic [DATA_W-1:0] ch_val      [NUM_CH];
  logic [DATA_W-1:0] prev_q      [NUM_CH];
  logic [DATA_W-1:0] slot_data_q [NUM_CH];
  logic [TS_W-1:0]   slot_ts_q   [NUM_CH];
  logic [CH_W-1:0]   gnt_idx;
  logic              grant;

  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [DATA_W-1:0] out_data_q;
  logic [TS_W-1:0]   out_ts_q;

  // A channel that was inactive last edge fires once on activation.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_val[k] = log_if.ch_data[k*DATA_W +: DATA_W];
    assign act[k]    = log_if.mon_en & log_if.ch_en[k];
    assign trig[k]   = act[k] & ((ch_val[k] != prev_q[k]) | ~act_q[k]);
  end

  // Pending slots of channels disabled this edge are discarded, never granted.
  assign req   = pend_q & act;
  assign grant = (~out_valid_q | log_if.log_ready) & (|req);

  mon_rr_arbiter #(
    .NUM_CH    (NUM_CH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (grant),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!act[k])                pend_d[k] = 1'b0;
      else if (trig[k])           pend_d[k] = 1'b1;
      else if (grant && gnt[k])   pend_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstamp_q <= '0;
      act_q    <= '0;
      pend_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k]      <= '0;
        slot_data_q[k] <= '0;
        slot_ts_q[k]   <= '0;
      end
    end else begin
      tstamp_q <= tstamp_q + TS_W'(1);
      act_q    <= act;
      pend_q   <= pend_d;
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k] <= ch_val[k];
        if (trig[k]) begin
          slot_data_q[k] <= ch_val[k];
          slot_ts_q[k]   <= tstamp_q;
        end
      end
    end
  end

  // Grant reads the slot before this edge's capture overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ts_q    <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= gnt_idx;
      out_data_q  <= slot_data_q[gnt_idx];
      out_ts_q    <= slot_ts_q[gnt_idx];
    end else if (log_if.log_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign log_if.log_valid = out_valid_q;
  assign log_if.log_ch    = out_ch_q;
  assign log_if.log_data  = out_data_q;
  assign log_if.log_ts    = out_ts_q;

`ifdef MON_DROP_CNT_EN
  logic [NUM_CH-1:0] drop;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign drop = trig & pend_q & ~(gnt & {NUM_CH{grant}});

  always_comb begin : drop_sum
    logic [DROP_W:0] sum;
    sum = {1'b0, drop_cnt_q};
    for (int k = 0; k < NUM_CH; k++) sum = sum + (DROP_W+1)'(drop[k]);
    drop_cnt_d = sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_monitor_event_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_monitor_event_scheduler
// Purpose  : Directed scenarios plus random traffic against an event-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_monitor_event_scheduler;
  import monitor_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int TS_W   = 16;
  localparam int TS_MOD = 1 << TS_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  monitor_event_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)) log_if ();

`ifdef MON_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  monitor_event_scheduler #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .TS_W     (TS_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .log_if   (log_if)
`ifdef MON_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event-level reference: per-channel "last seen" value, a one-deep
  // latest-wins mailbox, and a single output register shared round-robin.
  int m_ts;
  int m_prev     [NUM_CH];
  bit m_was_on   [NUM_CH];
  bit m_has_evt  [NUM_CH];
  int m_box_data [NUM_CH];
  int m_box_ts   [NUM_CH];
  bit m_valid;
  int m_ch, m_data, m_tsout;
  int m_next;
  int m_drops;

  function automatic int get_ch(input int k);
    return int'(log_if.ch_data[k*DATA_W +: DATA_W]);
  endfunction

  task automatic set_ch(input int k, input int v);
    log_if.ch_data[k*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  function automatic bit is_on(input int k);
    return log_if.mon_en && log_if.ch_en[k];
  endfunction

  task automatic model_reset();
    m_ts = 0; m_valid = 0; m_ch = 0; m_data = 0; m_tsout = 0; m_next = 0; m_drops = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_prev[k] = 0; m_was_on[k] = 0; m_has_evt[k] = 0; m_box_data[k] = 0; m_box_ts[k] = 0;
    end
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (!m_valid || log_if.log_ready) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (m_next + i) % NUM_CH;
        if (g < 0 && m_has_evt[c] && is_on(c)) g = c;
      end
    end
    if (g >= 0) begin
      m_valid = 1; m_ch = g; m_data = m_box_data[g]; m_tsout = m_box_ts[g];
      m_has_evt[g] = 0;
      m_next = (g + 1) % NUM_CH;
    end else if (log_if.log_ready) begin
      m_valid = 0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      int d;
      d = get_ch(k);
      if (!is_on(k)) begin
        m_has_evt[k] = 0;
      end else if (d != m_prev[k] || !m_was_on[k]) begin
        if (m_has_evt[k] && m_drops < 65535) m_drops++;
        m_has_evt[k] = 1; m_box_data[k] = d; m_box_ts[k] = m_ts;
      end
      m_prev[k] = d;
      m_was_on[k] = is_on(k);
    end
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic compare_all();
    chk("log_valid", 32'(log_if.log_valid), 32'(m_valid));
    chk("log_ch",    32'(log_if.log_ch),    32'(m_ch));
    chk("log_data",  32'(log_if.log_data),  32'(m_data));
    chk("log_ts",    32'(log_if.log_ts),    32'(m_tsout));
`ifdef MON_DROP_CNT_EN
    chk("drop_cnt",  32'(drop_cnt),         32'(m_drops));
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_ev(input int ch, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      cycle();
      if (log_if.log_valid && int'(log_if.log_ch) == ch) ok = 1;
    end
  endtask

  initial begin
    int q[$];
    int n_ev;
    int cap;
    bit ok;
`ifdef MON_DROP_CNT_EN
    int drops0;
`endif

    rst_n = 1'b0;
    log_if.mon_en = 1'b0; log_if.ch_en = '0; log_if.ch_data = '0; log_if.log_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(log_if.log_valid), 32'd0);
    chk("rst_ch",    32'(log_if.log_ch),    32'd0);
    chk("rst_data",  32'(log_if.log_data),  32'd0);
    chk("rst_ts",    32'(log_if.log_ts),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: enabling ch0 with a constant value yields exactly one event at ts 0
    log_if.mon_en = 1'b1; log_if.ch_en = 4'b0001; log_if.log_ready = 1'b1;
    n_ev = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (log_if.log_valid) begin
        n_ev++;
        chk("t1_ch", 32'(log_if.log_ch), 32'd0);
        chk("t1_ts", 32'(log_if.log_ts), 32'd0);
      end
    end
    chk("t1_count", 32'(n_ev), 32'd1);

    // 2: simultaneous change on ch0 and ch2, pointer sits at 3 after ch2's initial event
    log_if.ch_en = 4'b0101;
    for (int i = 0; i < 3; i++) cycle();
    set_ch(0, 8'h11); set_ch(2, 8'h22);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (log_if.log_valid) q.push_back(int'(log_if.log_ch));
    end
    chk("t2_count", 32'(q.size()), 32'd2);
    if (q.size() >= 2) begin
      chk("t2_first",  32'(q[0]), 32'd0);
      chk("t2_second", 32'(q[1]), 32'd2);
    end

    // 3: stalled sink, ch1 changes twice; only the latest value survives
    set_ch(1, 5); log_if.ch_en = 4'b0111;
    for (int i = 0; i < 4; i++) cycle();
    log_if.log_ready = 1'b0;
    set_ch(0, 8'h33);
    cycle(); cycle();
`ifdef MON_DROP_CNT_EN
    drops0 = int'(drop_cnt);
`endif
    set_ch(1, 6); cycle();
    set_ch(1, 7); cycle();
    log_if.log_ready = 1'b1;
    wait_ev(1, 8, ok);
    chk("t3_seen", 32'(ok), 32'd1);
    chk("t3_data", 32'(log_if.log_data), 32'd7);
`ifdef MON_DROP_CNT_EN
    chk("t3_drops", 32'(int'(drop_cnt) - drops0), 32'd1);
`endif

    // 4: disable while ch3 pending discards it; re-enable emits current value
    log_if.log_ready = 1'b0;
    set_ch(0, 8'h34);
    cycle(); cycle();
    set_ch(3, 8'h44); log_if.ch_en = 4'b1111;
    cycle();
    log_if.mon_en = 1'b0;
    cycle();
    log_if.log_ready = 1'b1;
    n_ev = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (log_if.log_valid && log_if.log_ch == 2'd3) n_ev++;
    end
    chk("t4_none", 32'(n_ev), 32'd0);
    set_ch(3, 8'h55); log_if.mon_en = 1'b1;
    wait_ev(3, 10, ok);
    chk("t4_seen", 32'(ok), 32'd1);
    chk("t4_data", 32'(log_if.log_data), 32'h55);

    // 5: asynchronous reset while stalled
    for (int i = 0; i < 6; i++) cycle();
    log_if.log_ready = 1'b0; log_if.ch_en = 4'b0001;
    set_ch(0, 8'h66);
    cycle(); cycle();
    chk("t5_stalled", 32'(log_if.log_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(log_if.log_valid), 32'd0);
    chk("t5_async_ts",    32'(log_if.log_ts),    32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    log_if.log_ready = 1'b1;
    wait_ev(0, 6, ok);
    chk("t5_seen", 32'(ok), 32'd1);
    chk("t5_ts",   32'(log_if.log_ts),   32'd0);
    chk("t5_data", 32'(log_if.log_data), 32'h66);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) log_if.mon_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) log_if.ch_en = 4'($urandom);
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 3) == 0) set_ch(k, int'($urandom_range(0, 3)));
      log_if.log_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // 6: timestamp wrap
    log_if.mon_en = 1'b1; log_if.ch_en = 4'b0001; log_if.log_ready = 1'b1;
    for (int i = 0; i < TS_MOD + 5; i++) cycle();
    set_ch(0, get_ch(0) ^ 8'hA5);
    cap = m_ts;
    wait_ev(0, 6, ok);
    chk("t6_seen", 32'(ok), 32'd1);
    chk("t6_ts",   32'(log_if.log_ts), 32'(cap));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
